// File: rtl/cfg_loader_pkg.sv
// Shared types and default sizing for the serial configuration loader.
package cfg_loader_pkg;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_MAX_BITS = 512;
  localparam int DEF_WORD_W   = 16;
  localparam int DEF_DIV_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SYNC  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_pattern_mem.sv
// Per-channel pattern store: word-wide writes, single-bit combinational read.
module cfg_pattern_mem
  import cfg_loader_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int WORD_W   = DEF_WORD_W
) (
  input  logic                                clk_i,
  input  logic                                we_i,
  input  logic [idx_w(NUM_CH)-1:0]            wr_ch_i,
  input  logic [idx_w(MAX_BITS/WORD_W)-1:0]   wr_addr_i,
  input  logic [WORD_W-1:0]                   wr_data_i,
  input  logic [idx_w(MAX_BITS)-1:0]          rd_bit_i,
  output logic [NUM_CH-1:0]                   rd_data_o
);

  localparam int DEPTH  = MAX_BITS / WORD_W;
  localparam int ADDR_W = idx_w(DEPTH);
  localparam int SEL_W  = idx_w(WORD_W);
  localparam int CH_W   = idx_w(NUM_CH);

  // Bit index splits into word address (upper) and bit-in-word (lower); WORD_W is a power of two.
  logic [ADDR_W-1:0] rd_word;
  logic [SEL_W-1:0]  rd_sel;

  assign rd_word = rd_bit_i[SEL_W +: ADDR_W];
  assign rd_sel  = rd_bit_i[SEL_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WORD_W-1:0] pat_mem [DEPTH];

      always_ff @(posedge clk_i) begin
        if (we_i && (wr_ch_i == CH_W'(gi))) begin
          pat_mem[wr_addr_i] <= wr_data_i;
        end
      end

      assign rd_data_o[gi] = pat_mem[rd_word][rd_sel];
    end
  endgenerate

endmodule

// File: rtl/serial_cfg_loader.sv
// Shifts stored per-channel bit patterns out on a shared divided serial clock,
// followed by an end-of-frame sync period.
module serial_cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic                               clk_in,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [idx_w(NUM_CH)-1:0]           wr_ch,
  input  logic [idx_w(MAX_BITS/WORD_W)-1:0]  wr_addr,
  input  logic [WORD_W-1:0]                  wr_data,
  input  logic [$clog2(MAX_BITS+1)-1:0]      frame_len,
  input  logic [DIV_W-1:0]                   clk_div,
  input  logic [NUM_CH-1:0]                  ch_mask,
  input  logic                               trig,
  input  logic                               dump,
  output logic                               sclk,
  output logic [NUM_CH-1:0]                  din,
  output logic                               syn,
  output logic [NUM_CH-1:0]                  out_en,
  output logic                               clk_out_en,
  output logic                               busy,
  output logic                               done,
  output logic                               aborted
);

  localparam int LEN_W = $clog2(MAX_BITS+1);
  localparam int BIT_W = idx_w(MAX_BITS);
  localparam int CNT_W = DIV_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0]    div_q, div_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DIV_W-1:0]    half_q, half_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                aborted_q, aborted_d;
  logic                trig_q;

  logic                trig_rise;
  logic                period_last;
  logic                last_bit;
  logic [NUM_CH-1:0]   pat_bits;

  cfg_pattern_mem #(
    .NUM_CH   (NUM_CH),
    .MAX_BITS (MAX_BITS),
    .WORD_W   (WORD_W)
  ) u_mem (
    .clk_i     (clk_in),
    .we_i      (wr_en & ~busy),
    .wr_ch_i   (wr_ch),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_bit_i  (bit_q),
    .rd_data_o (pat_bits)
  );

  assign trig_rise = trig & ~trig_q;
  // Divider runs 0..2H-1 per bit period; 2H-1 equals {clk_div, 1}.
  assign period_last = (div_q == {half_q, 1'b1});
  assign last_bit    = (LEN_W'(bit_q) == (len_q - LEN_W'(1)));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      div_q     <= '0;
      len_q     <= '0;
      half_q    <= '0;
      mask_q    <= '0;
      aborted_q <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      len_q     <= len_d;
      half_q    <= half_d;
      mask_q    <= mask_d;
      aborted_q <= aborted_d;
      trig_q    <= trig;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    div_d     = div_q;
    len_d     = len_q;
    half_d    = half_q;
    mask_d    = mask_q;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_rise && !dump && (frame_len != '0)) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
          div_d   = '0;
          len_d   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
          half_d  = clk_div;
          mask_d  = ch_mask;
        end
      end
      ST_SHIFT: begin
        if (period_last) begin
          div_d = '0;
          if (last_bit) begin
            state_d = ST_SYNC;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SYNC: begin
        if (period_last) begin
          state_d = ST_DONE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every other transition once a frame is under way.
    if (dump && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      bit_d     = '0;
      div_d     = '0;
      aborted_d = 1'b1;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign clk_out_en = (state_q == ST_SHIFT);
  assign sclk       = (state_q == ST_SHIFT) && (div_q > {1'b0, half_q});
  assign din        = (state_q == ST_SHIFT) ? (pat_bits & mask_q) : '0;
  assign syn        = (state_q == ST_SYNC);
  assign out_en     = ((state_q == ST_SHIFT) || (state_q == ST_SYNC)) ? mask_q : '0;
  assign done       = (state_q == ST_DONE);
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_serial_cfg_loader.sv
// Randomized and directed frames checked cycle by cycle against a timing model of the loader.
module tb_serial_cfg_loader;

  localparam int NCH  = 2;
  localparam int MAXB = 512;
  localparam int WW   = 16;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_ch = '0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [9:0]  frame_len = '0;
  logic [7:0]  clk_div = '0;
  logic [1:0]  ch_mask = '0;
  logic        trig = 1'b0;
  logic        dump = 1'b0;
  logic        sclk;
  logic [1:0]  din;
  logic        syn;
  logic [1:0]  out_en;
  logic        clk_out_en;
  logic        busy;
  logic        done;
  logic        aborted;

  serial_cfg_loader dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_len  (frame_len),
    .clk_div    (clk_div),
    .ch_mask    (ch_mask),
    .trig       (trig),
    .dump       (dump),
    .sclk       (sclk),
    .din        (din),
    .syn        (syn),
    .out_en     (out_en),
    .clk_out_en (clk_out_en),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_mem [NCH][MAXB];
  int done_cyc;
  int abort_cyc;
  int bits_seen;
  logic [MAXB-1:0] cap0;
  logic [MAXB-1:0] cap1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // {busy, done, aborted, syn, clk_out_en, sclk, out_en[1:0], din[1:0]}
  function automatic logic [9:0] pins();
    return {busy, done, aborted, syn, clk_out_en, sclk, out_en, din};
  endfunction

  // Expected pins at cycle t after the trigger cycle, from the frame timing rules.
  function automatic logic [9:0] model_out(input int t, input int len, input int h,
                                           input logic [1:0] m, input int dump_at);
    logic [9:0] r;
    int nb, k, ph;
    r  = '0;
    nb = 2 * h * len;
    if (len == 0) return r;
    if (dump_at > 0 && t > dump_at) begin
      if (t == dump_at + 1) r[7] = 1'b1;
      return r;
    end
    if (t >= 1 && t <= nb) begin
      k  = (t - 1) / (2 * h);
      ph = (t - 1) % (2 * h);
      r[9]   = 1'b1;
      r[5]   = 1'b1;
      r[4]   = (ph >= h);
      r[3:2] = m;
      r[1]   = model_mem[1][k] & m[1];
      r[0]   = model_mem[0][k] & m[0];
    end else if (t > nb && t <= nb + 2 * h) begin
      r[9]   = 1'b1;
      r[6]   = 1'b1;
      r[3:2] = m;
    end else if (t == nb + 2 * h + 1) begin
      r[9] = 1'b1;
      r[8] = 1'b1;
    end
    return r;
  endfunction

  task automatic mem_write(input int ch, input int addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_ch   = 1'(ch);
    wr_addr = 5'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    for (int b = 0; b < WW; b++) model_mem[ch][addr * WW + b] = data[b];
  endtask

  task automatic run_frame(input string name, input int len_req, input int div,
                           input logic [1:0] m, input int dump_at, input int poke_at,
                           input int rst_at, input bit cowrite);
    int len, h, tend, wch, waddr;
    logic [15:0] wdat;
    logic prev_sclk;
    bit hold;
    len  = (len_req > MAXB) ? MAXB : len_req;
    h    = div + 1;
    tend = (len == 0) ? 6 : 2 * h * len + 2 * h + 4;
    hold = (poke_at > 0);
    done_cyc  = -1;
    abort_cyc = -1;
    bits_seen = 0;
    cap0 = '0;
    cap1 = '0;
    prev_sclk = 1'b0;
    frame_len = 10'(len_req);
    clk_div   = 8'(div);
    ch_mask   = m;
    trig      = 1'b1;
    if (cowrite) begin
      wch   = $urandom_range(0, 1);
      waddr = $urandom_range(0, 31);
      wdat  = 16'($urandom);
      wr_en = 1'b1; wr_ch = 1'(wch); wr_addr = 5'(waddr); wr_data = wdat;
      for (int b = 0; b < WW; b++) model_mem[wch][waddr * WW + b] = wdat[b];
    end
    for (int t = 1; t <= tend; t++) begin
      tick();
      wr_en = 1'b0;
      if (!hold) trig = 1'b0;
      if (done && done_cyc < 0) done_cyc = t;
      if (aborted && abort_cyc < 0) abort_cyc = t;
      if (sclk && !prev_sclk) bits_seen++;
      prev_sclk = sclk;
      if (len > 0 && ((t - 1) % (2 * h)) == h && ((t - 1) / (2 * h)) < MAXB) begin
        cap0[(t - 1) / (2 * h)] = din[0];
        cap1[(t - 1) / (2 * h)] = din[1];
      end
      check(name, 32'(pins()), 32'(model_out(t, len, h, m, dump_at)));
      dump = (t == dump_at);
      if (hold && t == poke_at) begin
        trig = 1'b0;
        wr_en = 1'b1; wr_ch = 1'b0; wr_addr = '0; wr_data = 16'h3C3C;
      end
      if (hold && t == poke_at + 1) trig = 1'b1;
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(pins()), 32'h0);
        repeat (2) tick();
        check("rst_hold", 32'(pins()), 32'h0);
        rst_n = 1'b1;
        tick();
        check("rst_release", 32'(pins()), 32'h0);
        break;
      end
    end
    trig = 1'b0; dump = 1'b0; wr_en = 1'b0;
    tick();
    $display("frame %s len=%0d div=%0d mask=%b done_cyc=%0d abort_cyc=%0d bits=%0d",
             name, len_req, div, m, done_cyc, abort_cyc, bits_seen);
  endtask

  initial begin
    int len, div, dump_at;
    logic [1:0] m;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset", 32'(pins()), 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle", 32'(pins()), 32'h0);

    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < MAXB / WW; a++) mem_write(c, a, 16'h0000);

    mem_write(0, 0, 16'hA5A5);
    run_frame("a5a5", 16, 0, 2'b01, -1, -1, -1, 1'b0);
    check("a5_done_cyc", done_cyc, 35);
    check("a5_bits", cap0[15:0], 16'hA5A5);
    check("a5_din1", cap1[15:0], 16'h0000);

    for (int a = 0; a < MAXB / WW; a++) begin
      mem_write(0, a, 16'h5555);
      mem_write(1, a, 16'hAAAA);
    end
    run_frame("l512", 512, 3, 2'b11, -1, -1, -1, 1'b0);
    check("l512_done_cyc", done_cyc, 4105);
    check("l512_bits", bits_seen, 512);
    check("l512_tail0", cap0[511:480], 32'h55555555);
    check("l512_tail1", cap1[511:480], 32'hAAAAAAAA);

    mem_write(0, 0, 16'hA5A5);
    run_frame("dump", 16, 0, 2'b01, 20, -1, -1, 1'b0);
    check("dump_no_done", done_cyc, -1);
    check("dump_abort_cyc", abort_cyc, 21);
    run_frame("restart", 16, 0, 2'b01, -1, -1, -1, 1'b0);
    check("restart_done_cyc", done_cyc, 35);
    check("restart_bits", cap0[15:0], 16'hA5A5);

    dump = 1'b1; trig = 1'b1; frame_len = 10'd16;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_dump_trig", 32'(pins()), 32'h0);
    end
    dump = 1'b0; trig = 1'b0;
    tick();

    run_frame("len0", 0, 0, 2'b11, -1, -1, -1, 1'b0);
    check("len0_bits", bits_seen, 0);
    run_frame("len600", 600, 0, 2'b11, -1, -1, -1, 1'b0);
    check("len600_bits", bits_seen, 512);
    check("len600_done_cyc", done_cyc, 1027);

    run_frame("poke", 16, 1, 2'b11, -1, 7, -1, 1'b0);
    check("poke_done_cyc", done_cyc, 69);
    run_frame("readback", 16, 1, 2'b11, -1, -1, -1, 1'b0);
    check("readback_ch0", cap0[15:0], 16'hA5A5);
    check("readback_ch1", cap1[15:0], 16'hAAAA);

    run_frame("rst", 16, 0, 2'b01, -1, -1, 10, 1'b0);
    run_frame("post_rst", 16, 0, 2'b01, -1, -1, -1, 1'b0);
    check("post_rst_done_cyc", done_cyc, 35);

    for (int i = 0; i < 12; i++) begin
      for (int w = 0; w < 3; w++)
        mem_write($urandom_range(0, 1), $urandom_range(0, 31), 16'($urandom));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(500, 600) : $urandom_range(1, 40);
      div = $urandom_range(0, 3);
      m   = 2'($urandom_range(0, 3));
      dump_at = -1;
      if ($urandom_range(0, 3) == 0) begin
        dump_at = $urandom_range(1, 2 * (div + 1) * ((len > MAXB) ? MAXB : len) + 2 * (div + 1));
      end
      run_frame("rand", len, div, m, dump_at, -1, -1, 1'($urandom_range(0, 1)));
      if (dump_at < 0) check("rand_done_cyc", done_cyc,
                             2 * (div + 1) * ((len > MAXB) ? MAXB : len) + 2 * (div + 1) + 1);
      else check("rand_abort_cyc", abort_cyc, dump_at + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
